// File: rtl/fetch_sequencer.sv
// Program-counter controller for the instruction ROM: sequential fetch, stall, redirect, halt-word and fault handling.
// Optional macro ALIGN_TRAP_EN: misaligned redirect targets halt with fault 01 instead of being word-aligned.
module fetch_sequencer #(
  parameter int                ADDR_W     = 32,
  parameter int                MEM_SIZE   = 256,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] HALT_INSTR = 32'h0000_000C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              resume,
  input  logic [ADDR_W-1:0] instr_in,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              halted,
  output logic [1:0]        fault_code,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_STALL, S_HALT} state_t;

  localparam logic [ADDR_W:0] PC_LIMIT = (ADDR_W+1)'(MEM_SIZE * 4);
  localparam logic [1:0]      F_NONE   = 2'b00;
  localparam logic [1:0]      F_ALIGN  = 2'b01;
  localparam logic [1:0]      F_RANGE  = 2'b10;

  state_t            r_state, w_next_state;
  logic [ADDR_W-1:0] r_pc, w_next_pc;
  logic [1:0]        r_fault, w_next_fault;
  logic [31:0]       r_count, w_next_count;

  logic [ADDR_W-1:0] w_pc_plus4;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_target_raw;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_cand;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_halt_word;

  assign w_pc_plus4   = r_pc + ADDR_W'(4);
  assign w_redirect   = jump | branch_taken;
  assign w_target_raw = jump ? jump_target : branch_target;
  assign w_halt_word  = (instr_in == HALT_INSTR);

`ifdef ALIGN_TRAP_EN
  assign w_target     = w_target_raw;
  assign w_misaligned = w_redirect && (w_target_raw[1:0] != 2'b00);
`else
  assign w_target     = w_target_raw & ~ADDR_W'(3);
  assign w_misaligned = 1'b0;
`endif

  // Candidate next PC before the range check; a held stall keeps the current PC.
  assign w_cand         = w_redirect ? w_target : (stall ? r_pc : w_pc_plus4);
  assign w_out_of_range = ({1'b0, w_cand} >= PC_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_fault <= F_NONE;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_fault <= w_next_fault;
      r_count <= w_next_count;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_fault = r_fault;
    w_next_count = r_count;
    case (r_state)
      S_BOOT: w_next_state = S_RUN;
      S_RUN, S_STALL: begin
        if (w_halt_word) begin
          w_next_state = S_HALT;
          w_next_fault = F_NONE;
        end else if (w_misaligned) begin
          w_next_state = S_HALT;
          w_next_fault = F_ALIGN;
        end else if (w_out_of_range) begin
          w_next_state = S_HALT;
          w_next_fault = F_RANGE;
        end else if (w_redirect || !stall) begin
          w_next_state = S_RUN;
          w_next_pc    = w_cand;
          w_next_count = r_count + 32'd1;
        end else begin
          w_next_state = S_STALL;
        end
      end
      S_HALT: begin
        if (resume) begin
          w_next_state = S_BOOT;
          w_next_pc    = RESET_PC;
          w_next_fault = F_NONE;
        end
      end
      default: w_next_state = S_BOOT;
    endcase
  end

  always_comb begin
    instr_valid = (r_state == S_RUN) || (r_state == S_STALL);
    halted      = (r_state == S_HALT);
    instr_out   = instr_valid ? instr_in : '0;
    imem_addr   = r_pc;
    pc          = r_pc;
    pc_plus4    = w_pc_plus4;
    fault_code  = r_fault;
    fetch_count = r_count;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then randomized cycles against a cycle-level reference model.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0000_000C;
  localparam int M_BOOT = 0, M_RUN = 1, M_STALL = 2, M_HALT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump, resume;
  logic [31:0] branch_target, jump_target, instr_in;
  logic [31:0] imem_addr, pc, pc_plus4, instr_out, fetch_count;
  logic        instr_valid, halted;
  logic [1:0]  fault_code;

  logic [31:0] rom [256];

  int          n_cmp  = 0;
  int          n_fail = 0;

  int          m_state;
  logic [31:0] m_pc, m_cnt;
  logic [1:0]  m_fault;

  always #5 clk = ~clk;

  assign instr_in = rom[pc[9:2]];

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .resume(resume), .instr_in(instr_in), .imem_addr(imem_addr), .pc(pc),
    .pc_plus4(pc_plus4), .instr_out(instr_out), .instr_valid(instr_valid),
    .halted(halted), .fault_code(fault_code), .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_BOOT;
    m_pc    = 32'h0;
    m_cnt   = 32'h0;
    m_fault = 2'b00;
  endtask

  task automatic check_model();
    logic valid;
    valid = (m_state == M_RUN) || (m_state == M_STALL);
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, valid});
    chk("instr_out", instr_out, valid ? rom[m_pc / 4] : 32'h0);
    chk("halted", {31'b0, halted}, {31'b0, m_state == M_HALT});
    chk("fault_code", {30'b0, fault_code}, {30'b0, m_fault});
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  // One clock of the fetch rules applied to the model, using the inputs currently driven.
  task automatic model_step();
    logic [31:0] tgt, npc;
    logic        redir;
    if (m_state == M_BOOT) begin
      m_state = M_RUN;
    end else if (m_state == M_HALT) begin
      if (resume) begin
        m_state = M_BOOT;
        m_pc    = 32'h0;
        m_fault = 2'b00;
      end
    end else if (rom[m_pc / 4] == HALT) begin
      m_state = M_HALT;
      m_fault = 2'b00;
    end else begin
      redir = jump || branch_taken;
      tgt   = jump ? jump_target : branch_target;
`ifdef ALIGN_TRAP_EN
      if (redir && (tgt % 4) != 0) begin
        m_state = M_HALT;
        m_fault = 2'b01;
        return;
      end
`else
      tgt = tgt - (tgt % 4);
`endif
      if (redir)      npc = tgt;
      else if (stall) npc = m_pc;
      else            npc = m_pc + 4;
      if (npc >= 32'd1024) begin
        m_state = M_HALT;
        m_fault = 2'b10;
      end else if (redir || !stall) begin
        m_state = M_RUN;
        m_pc    = npc;
        m_cnt   = m_cnt + 1;
      end else begin
        m_state = M_STALL;
      end
    end
  endtask

  // Entered and left at posedge+1.
  task automatic step(input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input logic r);
    stall = s; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt; resume = r;
    @(negedge clk);
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 0; branch_taken = 0; jump = 0; resume = 0;
    branch_target = 0; jump_target = 0;
    for (int i = 0; i < 256; i++) rom[i] = NOP;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_fault", {30'b0, fault_code}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_instr_out", instr_out, 32'h0);
    rst_n = 1'b1;

    // BOOT, three RUN fetches, stall three cycles at pc=8, then continue.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("stall_pc_held", pc, 32'h8);
    chk("stall_count_held", fetch_count, 32'd2);
    step(0, 0, 0, 0, 0, 0);
    chk("after_stall_pc", pc, 32'hC);
    chk("after_stall_count", fetch_count, 32'd3);

    // Jump outranks branch.
    step(0, 1, 32'h20, 1, 32'h40, 0);
    chk("jump_prio_pc", pc, 32'h40);

    // Misaligned branch target.
    step(0, 1, 32'h22, 0, 0, 0);
`ifdef ALIGN_TRAP_EN
    chk("align_fault", {30'b0, fault_code}, 32'h1);
    chk("align_halted", {31'b0, halted}, 32'h1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
`else
    chk("align_mask_pc", pc, 32'h20);
`endif

    // Halt word at 0x10, then resume.
    rom[4] = HALT;
    step(0, 0, 0, 1, 32'h10, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("haltword_halted", {31'b0, halted}, 32'h1);
    chk("haltword_pc", pc, 32'h10);
    chk("haltword_fault", {30'b0, fault_code}, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("resume_pc", pc, 32'h0);
    chk("resume_boot_valid", {31'b0, instr_valid}, 32'h0);
    rom[4] = NOP;
    step(0, 0, 0, 0, 0, 0);

    // Sequential fetch off the end of the ROM.
    step(0, 0, 0, 1, 32'h3FC, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("range_halted", {31'b0, halted}, 32'h1);
    chk("range_fault", {30'b0, fault_code}, 32'h2);
    chk("range_pc", pc, 32'h3FC);
    step(0, 0, 0, 0, 0, 1);

    // Randomized phase over a ROM sprinkled with halt words.
    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom();
    for (int n = 0; n < 500; n++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 32'h47F),
           $urandom_range(0, 7) == 0, $urandom_range(0, 32'h47F), $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_count", fetch_count, 32'h0);
    chk("async_rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("async_rst_halted", {31'b0, halted}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = NOP;
    repeat (4) step(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
